// File: rtl/img_pkg.sv
// img_pkg: shared constants and state encoding for the image sequencing stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package img_pkg;

  localparam int DEF_ADDR_W = 10;  // column/result address width
  localparam int DEF_COL_W  = 24;  // 3 pixels x 8 bit
  localparam int DEF_RES_W  = 13;  // convolution result width
  localparam int KNL_SPAN   = 3;   // kernel width in columns
  localparam logic [7:0] WDOG_MAX = 8'd255;

  // Encoding is visible on o_state (LEDs/debug), so values are fixed.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/image_fsm_if.sv
// image_fsm_if: control strobes, GPIO/convolution data paths and MCU readback.
// Latency: n/a (wires only). slave = image_fsm side, master = control/test side.
// Backpressure: none; all strobes are single-cycle pulses or levels.
interface image_fsm_if import img_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int COL_W  = DEF_COL_W,
  parameter int RES_W  = DEF_RES_W
);
  logic              i_load;
  logic              i_run;
  logic              i_valid;
  logic [ADDR_W-1:0] i_imgLength;
  logic [COL_W-1:0]  i_GPIOdata;
  logic [RES_W-1:0]  i_CONVdata;
  logic              i_CONVvalid;
  logic [COL_W-1:0]  o_CONVcol;
  logic              o_CONVvalid;
  logic [RES_W-1:0]  o_MCUdata;
  logic              o_EOP;
  logic [2:0]        o_state;

  modport slave (
    input  i_load, i_run, i_valid, i_imgLength, i_GPIOdata, i_CONVdata, i_CONVvalid,
    output o_CONVcol, o_CONVvalid, o_MCUdata, o_EOP, o_state
  );

  modport master (
    output i_load, i_run, i_valid, i_imgLength, i_GPIOdata, i_CONVdata, i_CONVvalid,
    input  o_CONVcol, o_CONVvalid, o_MCUdata, o_EOP, o_state
  );
endinterface

// File: rtl/sp_ram.sv
// sp_ram: simple dual-port RAM, one write port, one always-enabled read port.
// Latency: 1 cycle registered read; read-during-write to same address returns old data.
// Backpressure: none. Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module sp_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/image_fsm.sv
// image_fsm: buffers one image of columns, streams them to the conv engine, collects
// results and returns them to the MCU. Ports: i_CLK/i_rst (sync, active-high), bus (slave).
// Latency: columns 1 cycle after issue; MCU word 1 cycle after i_valid. Backpressure: none.
// Optional: FSM_TIMEOUT_EN adds a DRAIN watchdog and the o_timeout port.
module image_fsm import img_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int COL_W  = DEF_COL_W,
  parameter int RES_W  = DEF_RES_W
) (
  input  logic  i_CLK,
  input  logic  i_rst,
  image_fsm_if.slave bus
`ifdef FSM_TIMEOUT_EN
  ,
  output logic  o_timeout
`endif
);
  localparam int DEPTH = 1 << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, len_q, len_d, ncol_q, ncol_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, res_ptr_q, res_ptr_d;
  logic [ADDR_W-1:0] nres_q, nres_d, out_ptr_q, out_ptr_d;
  logic              conv_vld_q, conv_vld_d, eop_q, eop_d, mcu_ok_q, mcu_ok_d;
  logic              img_we, res_we;
  logic [COL_W-1:0]  img_rdata;
  logic [RES_W-1:0]  res_rdata;
`ifdef FSM_TIMEOUT_EN
  logic [7:0]        wdog_q, wdog_d;
  logic              tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    len_d      = len_q;
    ncol_d     = ncol_q;
    rd_ptr_d   = rd_ptr_q;
    res_ptr_d  = res_ptr_q;
    nres_d     = nres_q;
    out_ptr_d  = out_ptr_q;
    conv_vld_d = 1'b0;
    img_we     = 1'b0;
    res_we     = 1'b0;
`ifdef FSM_TIMEOUT_EN
    wdog_d     = '0;
    tmo_d      = bus.i_load ? 1'b0 : tmo_q;
`endif

    // Result capture runs alongside streaming and is independent of i_valid.
    if ((state_q == STREAM || state_q == DRAIN) && bus.i_CONVvalid && res_ptr_q != nres_q) begin
      res_we    = 1'b1;
      res_ptr_d = res_ptr_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.i_load) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          len_d    = bus.i_imgLength;
        end
      end
      LOAD: begin
        if (bus.i_load) begin
          wr_ptr_d = '0;
          len_d    = bus.i_imgLength;
        end else begin
          if (bus.i_valid && wr_ptr_q != len_q) begin
            img_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          // A column written in the same cycle as i_run is still counted.
          if (bus.i_run) begin
            state_d   = STREAM;
            ncol_d    = wr_ptr_d;
            nres_d    = (wr_ptr_d >= ADDR_W'(KNL_SPAN)) ? wr_ptr_d - ADDR_W'(KNL_SPAN - 1) : '0;
            rd_ptr_d  = '0;
            res_ptr_d = '0;
          end
        end
      end
      STREAM: begin
        // Covers degenerate images (nres==0): no column is ever issued.
        if (res_ptr_q == nres_q) begin
          state_d = DONE;
        end else if (rd_ptr_q != ncol_q) begin
          conv_vld_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          if (rd_ptr_d == ncol_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (res_ptr_q == nres_q) begin
          state_d = DONE;
`ifdef FSM_TIMEOUT_EN
        end else if (bus.i_CONVvalid) begin
          wdog_d = '0;
        end else if (wdog_q == WDOG_MAX) begin
          state_d = DONE;
          nres_d  = res_ptr_q;
          tmo_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end
      DONE: begin
        if (bus.i_load) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          len_d    = bus.i_imgLength;
        end else if (bus.i_valid && out_ptr_q != nres_q) begin
          out_ptr_d = out_ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // out_ptr is 0 on DONE entry so res[0] is presented with EOP.
    if (state_d != DONE) out_ptr_d = '0;
    eop_d    = (state_d == DONE);
    mcu_ok_d = (state_d == DONE) && (out_ptr_d < nres_d);
  end

  always_ff @(posedge i_CLK) begin
    if (i_rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      len_q      <= '0;
      ncol_q     <= '0;
      rd_ptr_q   <= '0;
      res_ptr_q  <= '0;
      nres_q     <= '0;
      out_ptr_q  <= '0;
      conv_vld_q <= 1'b0;
      eop_q      <= 1'b0;
      mcu_ok_q   <= 1'b0;
`ifdef FSM_TIMEOUT_EN
      wdog_q     <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      len_q      <= len_d;
      ncol_q     <= ncol_d;
      rd_ptr_q   <= rd_ptr_d;
      res_ptr_q  <= res_ptr_d;
      nres_q     <= nres_d;
      out_ptr_q  <= out_ptr_d;
      conv_vld_q <= conv_vld_d;
      eop_q      <= eop_d;
      mcu_ok_q   <= mcu_ok_d;
`ifdef FSM_TIMEOUT_EN
      wdog_q     <= wdog_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  sp_ram #(.W(COL_W), .DEPTH(DEPTH), .AW(ADDR_W)) u_img (
    .clk   (i_CLK),
    .we    (img_we),
    .waddr (wr_ptr_q),
    .wdata (bus.i_GPIOdata),
    .raddr (rd_ptr_q),
    .rdata (img_rdata)
  );

  // Read address looks one cycle ahead so the word lands with the pointer update.
  sp_ram #(.W(RES_W), .DEPTH(DEPTH), .AW(ADDR_W)) u_res (
    .clk   (i_CLK),
    .we    (res_we),
    .waddr (res_ptr_q),
    .wdata (bus.i_CONVdata),
    .raddr (out_ptr_d),
    .rdata (res_rdata)
  );

  // RAM outputs are not reset; gating keeps the outputs 0 out of reset and past the end.
  assign bus.o_CONVcol   = conv_vld_q ? img_rdata : '0;
  assign bus.o_CONVvalid = conv_vld_q;
  assign bus.o_MCUdata   = mcu_ok_q ? res_rdata : '0;
  assign bus.o_EOP       = eop_q;
  assign bus.o_state     = state_q;
`ifdef FSM_TIMEOUT_EN
  assign o_timeout       = tmo_q;
`endif
endmodule

// File: tb/tb_image_fsm.sv
// tb_image_fsm: directed tests for image_fsm with a small convolution-engine echo model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Build with FSM_TIMEOUT_EN defined to include the watchdog scenario.
`timescale 1ns/1ps
module tb_image_fsm;
  import img_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  image_fsm_if bus ();
`ifdef FSM_TIMEOUT_EN
  logic timeout;
`endif

  image_fsm dut (
    .i_CLK (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef FSM_TIMEOUT_EN
    ,
    .o_timeout (timeout)
`endif
  );

  // Convolution model: echoes column[12:0] two cycles after each column from the
  // third one on, limited to res_limit results per image.
  int cyc = 0, ncols_seen = 0, nres_sent = 0, res_limit = 1000, last_strobe_cyc = 0;
  int conv_cnt = 0, first_cyc = 0, last_cyc = 0;
  logic [DEF_COL_W-1:0] col_log [$];
  logic s0_v = 1'b0, s1_v = 1'b0;
  logic [DEF_RES_W-1:0] s0_d = '0, s1_d = '0;

  always @(negedge clk) begin
    cyc++;
    bus.i_CONVvalid = s1_v;
    bus.i_CONVdata  = s1_d;
    if (s1_v) last_strobe_cyc = cyc;
    s1_v = s0_v;
    s1_d = s0_d;
    s0_v = 1'b0;
    if (bus.o_CONVvalid) begin
      if (conv_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      conv_cnt++;
      col_log.push_back(bus.o_CONVcol);
      if (ncols_seen >= KNL_SPAN - 1 && nres_sent < res_limit) begin
        s0_v = 1'b1;
        s0_d = bus.o_CONVcol[DEF_RES_W-1:0];
        nres_sent++;
      end
      ncols_seen++;
    end
  end

  logic [DEF_COL_W-1:0] basic_cols [8];
  logic [DEF_COL_W-1:0] short_cols [8];
  logic [DEF_COL_W-1:0] ovf_cols   [8];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_load(input int len);
    bus.i_load      = 1'b1;
    bus.i_imgLength = DEF_ADDR_W'(len);
    tick();
    bus.i_load      = 1'b0;
  endtask

  task automatic push_cols(input logic [DEF_COL_W-1:0] cols [8], input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_valid    = 1'b1;
      bus.i_GPIOdata = cols[i];
      tick();
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic start_run();
    conv_cnt   = 0;
    ncols_seen = 0;
    nres_sent  = 0;
    col_log.delete();
    bus.i_run = 1'b1;
    tick();
    bus.i_run = 1'b0;
  endtask

  task automatic wait_eop(input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (bus.o_EOP) break;
      tick();
    end
    ok = bus.o_EOP;
  endtask

  task automatic read_next();
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++; if (bus.o_state !== 3'd0)  begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.o_state); end
    n_tests++; if (bus.o_CONVvalid !== 1'b0) begin n_fail++; $display("FAIL reset_convvalid got %0b want 0", bus.o_CONVvalid); end
    n_tests++; if (bus.o_CONVcol !== 24'h0) begin n_fail++; $display("FAIL reset_convcol got %h want 0", bus.o_CONVcol); end
    n_tests++; if (bus.o_MCUdata !== 13'h0) begin n_fail++; $display("FAIL reset_mcudata got %h want 0", bus.o_MCUdata); end
    n_tests++; if (bus.o_EOP !== 1'b0) begin n_fail++; $display("FAIL reset_eop got %0b want 0", bus.o_EOP); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    logic [DEF_RES_W-1:0] exp_res [4];
    exp_res[0] = 13'h0405; exp_res[1] = 13'h0506; exp_res[2] = 13'h0607; exp_res[3] = 13'h0;
    start_load(5);
    n_tests++; if (bus.o_state !== 3'd1) begin n_fail++; $display("FAIL basic_load_state got %0d want 1", bus.o_state); end
    push_cols(basic_cols, 5);
    start_run();
    wait_eop(60, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_eop got 0 want 1"); end
    n_tests++; if (bus.o_state !== 3'd4) begin n_fail++; $display("FAIL basic_done_state got %0d want 4", bus.o_state); end
    n_tests++; if (conv_cnt != 5) begin n_fail++; $display("FAIL basic_col_count got %0d want 5", conv_cnt); end
    n_tests++; if (last_cyc - first_cyc != 4) begin n_fail++; $display("FAIL basic_consecutive got span %0d want 4", last_cyc - first_cyc); end
    for (int i = 0; i < 5 && i < col_log.size(); i++) begin
      n_tests++; if (col_log[i] !== basic_cols[i]) begin n_fail++; $display("FAIL basic_col%0d got %h want %h", i, col_log[i], basic_cols[i]); end
    end
    n_tests++; if (bus.o_CONVvalid !== 1'b0) begin n_fail++; $display("FAIL basic_convvalid_idle got 1 want 0"); end
    n_tests++; if (bus.o_MCUdata !== exp_res[0]) begin n_fail++; $display("FAIL basic_read0 got %h want %h", bus.o_MCUdata, exp_res[0]); end
    for (int i = 1; i < 5; i++) begin
      read_next();
      n_tests++;
      if (bus.o_MCUdata !== exp_res[i < 4 ? i : 3]) begin
        n_fail++; $display("FAIL basic_read%0d got %h want %h", i, bus.o_MCUdata, exp_res[i < 4 ? i : 3]);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_load(4);
    n_tests++; if (bus.o_EOP !== 1'b0) begin n_fail++; $display("FAIL b2b_eop_drop got %0b want 0", bus.o_EOP); end
    n_tests++; if (bus.o_state !== 3'd1) begin n_fail++; $display("FAIL b2b_state got %0d want 1", bus.o_state); end
  endtask

  task automatic test_short_load();
    bit ok;
    start_load(8);
    push_cols(short_cols, 4);
    start_run();
    wait_eop(60, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL short_eop got 0 want 1"); end
    n_tests++; if (conv_cnt != 4) begin n_fail++; $display("FAIL short_col_count got %0d want 4", conv_cnt); end
    n_tests++; if (bus.o_MCUdata !== 13'h1333) begin n_fail++; $display("FAIL short_read0 got %h want 1333", bus.o_MCUdata); end
    read_next();
    n_tests++; if (bus.o_MCUdata !== 13'h0444) begin n_fail++; $display("FAIL short_read1 got %h want 0444", bus.o_MCUdata); end
    read_next();
    n_tests++; if (bus.o_MCUdata !== 13'h0) begin n_fail++; $display("FAIL short_read2 got %h want 0", bus.o_MCUdata); end
  endtask

  task automatic test_degenerate();
    bit ok;
    start_load(2);
    push_cols(basic_cols, 2);
    start_run();
    wait_eop(2, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL degen_eop got 0 want 1 within 2 cycles"); end
    n_tests++; if (conv_cnt != 0) begin n_fail++; $display("FAIL degen_no_cols got %0d want 0", conv_cnt); end
    n_tests++; if (bus.o_MCUdata !== 13'h0) begin n_fail++; $display("FAIL degen_read0 got %h want 0", bus.o_MCUdata); end
    read_next();
    n_tests++; if (bus.o_MCUdata !== 13'h0) begin n_fail++; $display("FAIL degen_read1 got %h want 0", bus.o_MCUdata); end
  endtask

  task automatic test_overflow();
    bit ok;
    start_load(3);
    push_cols(ovf_cols, 6);
    start_run();
    wait_eop(60, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ovf_eop got 0 want 1"); end
    n_tests++; if (conv_cnt != 3) begin n_fail++; $display("FAIL ovf_col_count got %0d want 3", conv_cnt); end
    for (int i = 0; i < 3 && i < col_log.size(); i++) begin
      n_tests++; if (col_log[i] !== ovf_cols[i]) begin n_fail++; $display("FAIL ovf_col%0d got %h want %h", i, col_log[i], ovf_cols[i]); end
    end
    n_tests++; if (bus.o_MCUdata !== 13'h0003) begin n_fail++; $display("FAIL ovf_read0 got %h want 0003", bus.o_MCUdata); end
  endtask

  task automatic test_reset_mid_stream();
    bit ok;
    int waited;
    start_load(5);
    push_cols(basic_cols, 5);
    start_run();
    waited = 0;
    while (conv_cnt == 0 && waited < 10) begin tick(); waited++; end
    n_tests++; if (conv_cnt == 0) begin n_fail++; $display("FAIL rstmid_stream_start got 0 columns want >0"); end
    rst = 1'b1;
    tick();
    n_tests++; if (bus.o_state !== 3'd0) begin n_fail++; $display("FAIL rstmid_state got %0d want 0", bus.o_state); end
    n_tests++; if (bus.o_CONVvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_convvalid got %0b want 0", bus.o_CONVvalid); end
    n_tests++; if (bus.o_EOP !== 1'b0) begin n_fail++; $display("FAIL rstmid_eop got %0b want 0", bus.o_EOP); end
    rst = 1'b0;
    tick();
    tick();
    start_load(5);
    push_cols(basic_cols, 5);
    start_run();
    wait_eop(60, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_reload_eop got 0 want 1"); end
    n_tests++; if (conv_cnt != 5) begin n_fail++; $display("FAIL rstmid_reload_cols got %0d want 5", conv_cnt); end
    n_tests++; if (bus.o_MCUdata !== 13'h0405) begin n_fail++; $display("FAIL rstmid_reload_read0 got %h want 0405", bus.o_MCUdata); end
  endtask

`ifdef FSM_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int delta;
    res_limit = 2;
    start_load(5);
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear_on_load got %0b want 0", timeout); end
    push_cols(basic_cols, 5);
    start_run();
    wait_eop(400, ok);
    delta = cyc - last_strobe_cyc;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_eop got 0 want 1"); end
    n_tests++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_flag got %0b want 1", timeout); end
    n_tests++; if (delta < 255 || delta > 259) begin n_fail++; $display("FAIL tmo_delay got %0d want 255..259", delta); end
    n_tests++; if (bus.o_MCUdata !== 13'h0405) begin n_fail++; $display("FAIL tmo_read0 got %h want 0405", bus.o_MCUdata); end
    read_next();
    n_tests++; if (bus.o_MCUdata !== 13'h0506) begin n_fail++; $display("FAIL tmo_read1 got %h want 0506", bus.o_MCUdata); end
    read_next();
    n_tests++; if (bus.o_MCUdata !== 13'h0) begin n_fail++; $display("FAIL tmo_read2 got %h want 0", bus.o_MCUdata); end
    res_limit = 1000;
    start_load(3);
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_flag_cleared got %0b want 0", timeout); end
  endtask
`endif

  initial begin
    bus.i_load      = 1'b0;
    bus.i_run       = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_imgLength = '0;
    bus.i_GPIOdata  = '0;
    for (int i = 0; i < 8; i++) begin
      basic_cols[i] = '0;
      short_cols[i] = '0;
      ovf_cols[i]   = '0;
    end
    basic_cols[0] = 24'h010203; basic_cols[1] = 24'h020304; basic_cols[2] = 24'h030405;
    basic_cols[3] = 24'h040506; basic_cols[4] = 24'h050607;
    short_cols[0] = 24'h111111; short_cols[1] = 24'h222222; short_cols[2] = 24'h333333;
    short_cols[3] = 24'h444444;
    for (int i = 0; i < 6; i++) ovf_cols[i] = 24'hA00001 + 24'(i);

    test_reset();
    test_basic();
    test_back_to_back();
    test_short_load();
    test_degenerate();
    test_overflow();
    test_reset_mid_stream();
`ifdef FSM_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/image_fsm.md
Name: image_fsm

Overview:
- Sequencing stage directly downstream of the control block. Consumes its load, run, valid and image-length strobes and the GPIO pixel-column words.
- Buffers one image as 24-bit columns (3 x 8-bit pixels) and streams them, one per cycle, to the convolution engine.
- Captures the 13-bit convolution results into a result buffer and raises end-of-process (EOP).
- Returns results one word per valid pulse while the MCU is in data-request mode.

Parameters:
- ADDR_W, 10, column/result address width (max 1024 columns)
- COL_W, 24, image column width (3 pixels x 8 bit)
- RES_W, 13, convolution result width
- KNL_SPAN, 3, kernel width in columns; results per image = len - (KNL_SPAN-1)

Ports:
- i_CLK  in  1  clock, all logic posedge
- i_rst  in  1  synchronous reset, active-high
- i_load  in  1  one-cycle pulse: start a new image load
- i_run  in  1  level: loading finished, start processing
- i_valid  in  1  one-cycle pulse: a data word is present (load) or a result read is requested (out)
- i_imgLength  in  ADDR_W  image length in columns
- i_GPIOdata  in  COL_W  pixel column to store
- i_CONVdata  in  RES_W  convolution result
- i_CONVvalid  in  1  result strobe from the convolution engine
- o_CONVcol  out  COL_W  column fed to the convolution engine
- o_CONVvalid  out  1  column strobe to the convolution engine
- o_MCUdata  out  RES_W  result word returned to the MCU
- o_EOP  out  1  end of process, level
- o_state  out  3  current state encoding, for LEDs/debug

Behaviour:
- Reset:
  - state=IDLE; o_CONVvalid=0; o_CONVcol=0; o_MCUdata=0; o_EOP=0.
  - All pointers/counters cleared. Buffer contents are not cleared.
  - Reset in any state returns to IDLE within 1 cycle.
- States (o_state): IDLE=0, LOAD=1, STREAM=2, DRAIN=3, DONE=4.
- IDLE:
  - i_load -> LOAD; wr_ptr=0; len latched from i_imgLength on the same edge.
- LOAD:
  - Each i_valid writes i_GPIOdata to img[wr_ptr], then wr_ptr++.
  - Once wr_ptr==len, further valids are ignored; no wrap.
  - i_run -> STREAM with ncol=wr_ptr (a short load is processed as-is).
  - i_load in LOAD restarts the load: wr_ptr=0, len re-latched.
- STREAM:
  - Reads one column per cycle. o_CONVcol=img[rd_ptr] and o_CONVvalid=1 are registered, 1-cycle read latency.
  - After ncol columns -> DRAIN; o_CONVvalid=0 the cycle after the last column.
- Results:
  - Each i_CONVvalid (in STREAM or DRAIN) writes i_CONVdata to res[res_ptr], then res_ptr++.
  - Writes stop at nres = ncol-(KNL_SPAN-1); extra strobes are ignored.
- DRAIN:
  - res_ptr==nres -> DONE. This comparison is also checked in STREAM.
- Degenerate image: ncol < KNL_SPAN gives nres=0, and STREAM goes straight to DONE with no columns streamed.
- DONE:
  - o_EOP=1 (registered, asserted the cycle DONE is entered).
  - o_MCUdata=res[0] on entry.
  - Each i_valid: out_ptr++, o_MCUdata=res[out_ptr] the next cycle.
  - Reads past nres-1 return 0 and the pointer saturates.
  - i_load -> LOAD, o_EOP=0 on the same edge.
- i_valid and i_CONVvalid arriving in the same cycle are independent and both are honoured.
- All arithmetic is unsigned ADDR_W bits. ncol=0 is legal: DONE immediately.

Optional Feature:
- FSM_TIMEOUT_EN defined:
  - An 8-bit watchdog in DRAIN is cleared on every i_CONVvalid.
  - At 255 idle cycles it forces DONE with nres=res_ptr.
  - An extra port o_timeout (1 bit, reset 0) is set and stays set until the next i_load.
- Undefined: no watchdog and no o_timeout port; DRAIN waits indefinitely.

Decomposition:
- Package img_pkg holds the state encodings, KNL_SPAN, ADDR_W/COL_W/RES_W defaults, and WDOG_MAX=255.
- Sub-module sp_ram (simple dual-port, 1-cycle registered read, parameterised width/depth) is instantiated twice: img[] and res[].

Test Plan:
- Basic image:
  - Stimulus: i_load, len=5, 5 valids with columns 0x010203..0x050607, i_run; conv model echoes column[12:0] after 2 cycles, 3 results.
  - Required: 5 o_CONVvalid pulses in consecutive cycles; o_EOP rises; reads return 3 words, then 0.
- Short load:
  - Stimulus: len=8, only 4 valids, then i_run.
  - Required: exactly 4 columns streamed; nres=2; EOP after 2 results.
- Degenerate image:
  - Stimulus: len=2, 2 valids, i_run.
  - Required: no o_CONVvalid; DONE/EOP within 2 cycles; o_MCUdata reads 0.
- Overflow:
  - Stimulus: len=3, 6 valids.
  - Required: only the first 3 columns are stored and streamed.
- Reset mid-STREAM:
  - Stimulus: i_rst pulse during STREAM.
  - Required: next cycle state=0, o_CONVvalid=0, o_EOP=0; a new load then completes normally.
- Timeout (FSM_TIMEOUT_EN):
  - Stimulus: conv model drops the last result.
  - Required: 255 cycles after the last strobe, DONE is entered, o_timeout=1, and res_ptr results are readable.
